// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: codec-side I2S receiver clocked by the bus.
// sclk/lrck/sdi are oversampled in the clk domain. Standard I2S frames are deserialised:
// one delay bit after each lrck edge, then the data MSB first. Each left/right pair is
// presented on a valid/ready stream. A pair that completes while the output is still
// occupied is dropped and reported on ovf.
// Optional feature: define I2S_SLV_RX_FRAME_CHK_EN to add the frame_err short-slot detector.
`timescale 1ns/1ps
module i2s_slave_rx #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SYNC_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              lrck,
  input  logic              sdi,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              ovf
`ifdef I2S_SLV_RX_FRAME_CHK_EN
  ,
  output logic              frame_err
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser chains; index SYNC_W-1 is the settled sample
  logic [SYNC_W-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_W-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_W-1:0] sdi_sync_q,  sdi_sync_d;
  logic              sclk_dly_q,  sclk_dly_d;

  // Deserialiser state
  logic              started_q,   started_d;
  logic              lrck_prev_q, lrck_prev_d;
  logic              chan_q,      chan_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-2:0] shreg_q,     shreg_d;
  logic [DATA_W-1:0] lhold_q,     lhold_d;
  logic              have_left_q, have_left_d;

  // Output stage
  logic [DATA_W-1:0] out_left_q,  out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              out_vld_q,   out_vld_d;
  logic              ovf_q,       ovf_d;
`ifdef I2S_SLV_RX_FRAME_CHK_EN
  logic              frame_err_q, frame_err_d;
  logic              slot_short;
`endif

  logic              sclk_s, lrck_s, sdi_s;
  logic              tick;
  logic [DATA_W-1:0] word;
  logic              pair_done;

  assign sclk_s = sclk_sync_q[SYNC_W-1];
  assign lrck_s = lrck_sync_q[SYNC_W-1];
  assign sdi_s  = sdi_sync_q[SYNC_W-1];
  assign tick   = sclk_s & ~sclk_dly_q;
  // shreg holds only the first DATA_W-1 bits; the word is complete with the current sdi
  assign word   = {shreg_q, sdi_s};

  // Shift the external lines into the synchronisers and delay sclk for edge detection
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_W-2:0], sclk};
    lrck_sync_d = {lrck_sync_q[SYNC_W-2:0], lrck};
    sdi_sync_d  = {sdi_sync_q[SYNC_W-2:0],  sdi};
    sclk_dly_d  = sclk_s;
  end

  // Slot tracking and word assembly on each sclk rise
  always_comb begin
    started_d   = started_q;
    lrck_prev_d = lrck_prev_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    lhold_d     = lhold_q;
    have_left_d = have_left_q;
    pair_done   = 1'b0;
`ifdef I2S_SLV_RX_FRAME_CHK_EN
    slot_short  = 1'b0;
`endif
    if (tick) begin
      started_d   = 1'b1;
      lrck_prev_d = lrck_s;
      if (started_q && (lrck_s != lrck_prev_q)) begin
        // Slot start: this tick carries the delay bit, which is discarded
        bit_cnt_d = '0;
        chan_d    = lrck_s;
`ifdef I2S_SLV_RX_FRAME_CHK_EN
        slot_short = (bit_cnt_q < CNT_FULL);
        if (slot_short) begin
          have_left_d = 1'b0;
        end
`endif
      end else if (bit_cnt_q < CNT_FULL) begin
        shreg_d   = word[DATA_W-2:0];
        bit_cnt_d = bit_cnt_q + CNT_ONE;
        if (bit_cnt_q == CNT_LAST) begin
          if (!chan_q) begin
            lhold_d     = word;
            have_left_d = 1'b1;
          end else if (have_left_q) begin
            pair_done   = 1'b1;
            have_left_d = 1'b0;
          end
        end
      end
    end
  end

  // Output handshake: load on free or simultaneously-draining output, else drop and flag
  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_vld_d   = out_vld_q & ~out_rdy;
    ovf_d       = 1'b0;
    if (pair_done) begin
      if (!out_vld_q || out_rdy) begin
        out_left_d  = lhold_q;
        out_right_d = word;
        out_vld_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

`ifdef I2S_SLV_RX_FRAME_CHK_EN
  // Short-slot pulse
  always_comb begin
    frame_err_d = slot_short;
  end
`endif

  // State registers; bit_cnt resets saturated so nothing is captured before a real slot start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      lrck_sync_q <= '0;
      sdi_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      started_q   <= 1'b0;
      lrck_prev_q <= 1'b0;
      chan_q      <= 1'b0;
      bit_cnt_q   <= CNT_FULL;
      shreg_q     <= '0;
      lhold_q     <= '0;
      have_left_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef I2S_SLV_RX_FRAME_CHK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      started_q   <= started_d;
      lrck_prev_q <= lrck_prev_d;
      chan_q      <= chan_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      lhold_q     <= lhold_d;
      have_left_q <= have_left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_vld_q   <= out_vld_d;
      ovf_q       <= ovf_d;
`ifdef I2S_SLV_RX_FRAME_CHK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_vld   = out_vld_q;
  assign ovf       = ovf_q;
`ifdef I2S_SLV_RX_FRAME_CHK_EN
  assign frame_err = frame_err_q;
`endif

endmodule
